pllcfg_sequencer: RTL

Sequences one PLL reconfiguration transaction at a time, on command from the NIOS register interface. For each transaction it starts the reconfiguration engine, waits for completion, pulses the PLL reset, then waits for a stable lock. It produces the 10-bit PLLCFG status word, which software reads back through the status PIO. Timeouts are detected and reported so that software never hangs on a dead PLL.

---
 rtl/pllcfg_pkg.sv | 25 ++
 rtl/pllcfg_sync.sv | 26 ++
 rtl/pllcfg_sequencer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/pllcfg_pkg.sv
// Shared types and constants for the PLL reconfiguration sequencer.
package pllcfg_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWaitRcfg,
    StPrst,
    StWaitLock,
    StFin
  } state_e;

  localparam int unsigned ST_DONE     = 0;
  localparam int unsigned ST_BUSY     = 1;
  localparam int unsigned ST_RCFG_ERR = 2;
  localparam int unsigned ST_RCFG_TMO = 3;
  localparam int unsigned ST_LOCK_TMO = 4;
  localparam int unsigned ST_IND_LSB  = 5;
  localparam int unsigned StatusW     = 10;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pllcfg_sync.sv
// N-bit two-flop synchroniser for asynchronous level inputs.
module pllcfg_sync #(
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [Width-1:0] async_in,
  output logic [Width-1:0] sync_out
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/pllcfg_sequencer.sv
// One-at-a-time PLL reconfiguration sequencer: reconfig, PLL reset, wait for stable lock,
// with timeouts reported in the status word.
module pllcfg_sequencer
  import pllcfg_pkg::*;
#(
  parameter int unsigned N_PLL       = 2,
  parameter int unsigned RCFG_TMO    = 65535,
  parameter int unsigned RST_CYC     = 16,
  parameter int unsigned LOCK_STABLE = 256,
  parameter int unsigned LOCK_TMO    = 1048575
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [4:0]         cmd_pll_ind,
  input  logic               cmd_rst_only,
  input  logic               cmd_clr_err,
  output logic               rcfg_start,
  output logic [4:0]         rcfg_sel,
  input  logic               rcfg_done,
  input  logic               rcfg_err,
  output logic [N_PLL-1:0]   pll_areset,
  input  logic [N_PLL-1:0]   pll_locked,
  output logic [StatusW-1:0] status
);

  localparam int unsigned MaxPar = max_u(max_u(RCFG_TMO, RST_CYC), max_u(LOCK_STABLE, LOCK_TMO));
  localparam int unsigned CntW   = $clog2(MaxPar) + 1;

  state_e               state_q;
  logic                 cmd_ready_q;
  logic                 rcfg_start_q;
  logic [4:0]           rcfg_sel_q;
  logic [N_PLL-1:0]     pll_areset_q;
  logic [StatusW-1:0]   status_q;
  logic [CntW-1:0]      cnt_q;
  logic [CntW-1:0]      stab_q;

  logic [N_PLL-1:0]     lock_sync;
  logic [N_PLL-1:0]     sel_onehot;
  logic                 lock_cur;
  logic [CntW-1:0]      cnt_inc;
  logic [CntW-1:0]      stab_inc;
  logic [CntW-1:0]      stab_nxt;
  logic                 cmd_fire;
  logic                 ind_bad;

  pllcfg_sync #(
    .Width (N_PLL)
  ) u_lock_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (pll_locked),
    .sync_out (lock_sync)
  );

  // Mask-and-reduce avoids indexing the lock vector with an out-of-range index.
  assign sel_onehot = N_PLL'(1) << rcfg_sel_q;
  assign lock_cur   = |(lock_sync & sel_onehot);

  assign cnt_inc  = (&cnt_q)  ? cnt_q  : cnt_q  + CntW'(1);
  assign stab_inc = (&stab_q) ? stab_q : stab_q + CntW'(1);
  assign stab_nxt = lock_cur ? stab_inc : '0;

  assign cmd_fire = cmd_valid && cmd_ready_q;
  assign ind_bad  = 32'(cmd_pll_ind) >= N_PLL;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      cmd_ready_q  <= 1'b0;
      rcfg_start_q <= 1'b0;
      rcfg_sel_q   <= '0;
      pll_areset_q <= '0;
      status_q     <= StatusW'(1);
      cnt_q        <= '0;
      stab_q       <= '0;
    end else begin
      rcfg_start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          cmd_ready_q <= 1'b1;
          if (cmd_fire) begin
            if (cmd_clr_err) begin
              status_q[ST_LOCK_TMO:ST_RCFG_ERR] <= '0;
            end else if (ind_bad) begin
              status_q[ST_RCFG_ERR] <= 1'b1;
            end else begin
              cmd_ready_q                        <= 1'b0;
              rcfg_sel_q                         <= cmd_pll_ind;
              status_q[StatusW-1:ST_IND_LSB]     <= cmd_pll_ind;
              status_q[ST_LOCK_TMO:ST_RCFG_ERR]  <= '0;
              status_q[ST_BUSY]                  <= 1'b1;
              status_q[ST_DONE]                  <= 1'b0;
              cnt_q                              <= '0;
              if (cmd_rst_only) begin
                pll_areset_q <= N_PLL'(1) << cmd_pll_ind;
                state_q      <= StPrst;
              end else begin
                rcfg_start_q <= 1'b1;
                state_q      <= StStart;
              end
            end
          end
        end
        StStart: begin
          cnt_q   <= '0;
          state_q <= StWaitRcfg;
        end
        StWaitRcfg: begin
          cnt_q <= cnt_inc;
          // Completion takes priority over a timeout landing on the same cycle.
          if (rcfg_done) begin
            if (rcfg_err) begin
              status_q[ST_RCFG_ERR] <= 1'b1;
              state_q               <= StFin;
            end else begin
              pll_areset_q <= sel_onehot;
              cnt_q        <= '0;
              state_q      <= StPrst;
            end
          end else if (cnt_inc >= CntW'(RCFG_TMO)) begin
            status_q[ST_RCFG_TMO] <= 1'b1;
            state_q               <= StFin;
          end
        end
        StPrst: begin
          cnt_q <= cnt_inc;
          if (cnt_inc >= CntW'(RST_CYC)) begin
            pll_areset_q <= '0;
            cnt_q        <= '0;
            stab_q       <= '0;
            state_q      <= StWaitLock;
          end
        end
        StWaitLock: begin
          cnt_q  <= cnt_inc;
          stab_q <= stab_nxt;
          if (stab_nxt >= CntW'(LOCK_STABLE)) begin
            state_q <= StFin;
          end else if (cnt_inc >= CntW'(LOCK_TMO)) begin
            status_q[ST_LOCK_TMO] <= 1'b1;
            state_q               <= StFin;
          end
        end
        StFin: begin
          status_q[ST_BUSY] <= 1'b0;
          status_q[ST_DONE] <= 1'b1;
          cmd_ready_q       <= 1'b1;
          state_q           <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rcfg_start = rcfg_start_q;
  assign rcfg_sel   = rcfg_sel_q;
  assign pll_areset = pll_areset_q;
  assign status     = status_q;

endmodule
